// File: rtl/pattern_sequencer.sv
// pattern_sequencer: plays a latched per-channel bit pattern, one symbol per tick period, onto CHANNELS outputs
//   CLK, RST_N            clock, asynchronous active-low reset
//   pattern_in            channel c at [c*MESSAGE_WIDTH +: MESSAGE_WIDTH], symbol 0 in the LSB
//   length, tick_rate     symbols per pass, clock cycles per symbol (latched on load)
//   loop_mode             1 = repeat passes, 0 = one pass then return to IDLE
//   load_valid/load_ready load handshake; ready only in IDLE
//   abort                 return to IDLE from RUN without a done pulse
//   LED, blink_index      current symbol per channel and its index
//   busy, done            RUN status and one-cycle pass-complete pulse
module pattern_sequencer #(
  parameter int CHANNELS      = 4,
  parameter int MESSAGE_WIDTH = 102,
  parameter int TICK_WIDTH    = 32,
  parameter int LEN_WIDTH     = $clog2(MESSAGE_WIDTH + 1),
  parameter int IDX_WIDTH     = $clog2(MESSAGE_WIDTH)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [CHANNELS*MESSAGE_WIDTH-1:0] pattern_in,
  input  logic [LEN_WIDTH-1:0]              length,
  input  logic [TICK_WIDTH-1:0]             tick_rate,
  input  logic                              loop_mode,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic                              abort,
  output logic [CHANNELS-1:0]               LED,
  output logic [IDX_WIDTH-1:0]              blink_index,
  output logic                              busy,
  output logic                              done
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MESSAGE_WIDTH);
  state_t                            state_q, state_d;
  logic [CHANNELS*MESSAGE_WIDTH-1:0] pat_q, pat_d;
  logic [LEN_WIDTH-1:0]              len_q, len_d;
  logic [TICK_WIDTH-1:0]             rate_q, rate_d, presc_q, presc_d;
  logic                              loop_q, loop_d, done_q, done_d;
  logic [IDX_WIDTH-1:0]              idx_q, idx_d;
  logic                              tick, last;
  assign tick = presc_q == rate_q - TICK_WIDTH'(1);
  assign last = LEN_WIDTH'(idx_q) == len_q - LEN_WIDTH'(1);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rate_q  <= '0;
      loop_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rate_q  <= rate_d;
      loop_q  <= loop_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rate_d  = rate_q;
    loop_d  = loop_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (load_valid) begin
        state_d = RUN;
        pat_d   = pattern_in;
        len_d   = (length == '0 || length > MAX_LEN) ? MAX_LEN : length;
        rate_d  = (tick_rate == '0) ? TICK_WIDTH'(1) : tick_rate;
        loop_d  = loop_mode;
        presc_d = '0;
        idx_d   = '0;
      end
    end else if (abort) begin
      state_d = IDLE;
      presc_d = '0;
      idx_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      done_d  = last;
      idx_d   = last ? '0 : idx_q + IDX_WIDTH'(1);
      state_d = (last && !loop_q) ? IDLE : RUN;
    end else begin
      presc_d = presc_q + TICK_WIDTH'(1);
    end
  end
  assign busy        = state_q == RUN;
  assign load_ready  = state_q == IDLE;
  assign done        = done_q;
  assign blink_index = idx_q;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [MESSAGE_WIDTH-1:0] ch;
    assign ch     = pat_q[c*MESSAGE_WIDTH +: MESSAGE_WIDTH];
    assign LED[c] = busy & ch[idx_q];
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed checks of pattern_sequencer with 2 channels of 8 symbols
module tb_pattern_sequencer;
  localparam int CH = 2, MW = 8, TW = 32, LW = $clog2(MW + 1), IW = $clog2(MW);
  localparam logic [CH*MW-1:0] P1 = {8'b1111_0000, 8'b0000_1101};
  localparam logic [CH*MW-1:0] P2 = {8'h3C, 8'hA6};
  localparam logic [CH*MW-1:0] PH1 = {8'h02, 8'h01};
  localparam logic [CH*MW-1:0] PH2 = {8'h03, 8'h02};
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [CH*MW-1:0] pattern_in = '0;
  logic [LW-1:0] length = '0;
  logic [TW-1:0] tick_rate = '0;
  logic loop_mode = 1'b0, load_valid = 1'b0, abort = 1'b0;
  logic load_ready, busy, done;
  logic [CH-1:0] LED;
  logic [IW-1:0] blink_index;
  int checks = 0, errors = 0;
  pattern_sequencer #(.CHANNELS(CH), .MESSAGE_WIDTH(MW), .TICK_WIDTH(TW)) dut (
    .CLK(CLK), .RST_N(RST_N), .pattern_in(pattern_in), .length(length),
    .tick_rate(tick_rate), .loop_mode(loop_mode), .load_valid(load_valid),
    .load_ready(load_ready), .abort(abort), .LED(LED), .blink_index(blink_index),
    .busy(busy), .done(done)
  );
  always #5 CLK = ~CLK;
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [CH*MW-1:0] p, input logic [LW-1:0] l, input logic [TW-1:0] r, input logic m);
    pattern_in = p;
    length     = l;
    tick_rate  = r;
    loop_mode  = m;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
  endtask
  function automatic logic [1:0] sym(input logic [CH*MW-1:0] p, input int i);
    return {p[MW+i], p[i]};
  endfunction
  initial begin
    step(2);
    chk("rst_led", LED, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", blink_index, 0);
    chk("rst_ready", load_ready, 1);
    RST_N = 1'b1;
    step(1);
    chk("idle_ready", load_ready, 1);
    load(P1, 4, 3, 1'b0);
    for (int n = 0; n < 12; n++) begin
      chk("os_led", LED, sym(P1, n / 3));
      chk("os_busy", busy, 1);
      chk("os_done", done, 0);
      chk("os_ready", load_ready, 0);
      step(1);
    end
    chk("os_done_end", done, 1);
    chk("os_busy_end", busy, 0);
    chk("os_led_end", LED, 0);
    chk("os_ready_end", load_ready, 1);
    step(1);
    chk("os_done_clr", done, 0);
    load(P1, 4, 3, 1'b1);
    for (int n = 0; n < 30; n++) begin
      chk("lp_idx", blink_index, (n / 3) % 4);
      chk("lp_busy", busy, 1);
      chk("lp_done", done, (n == 12 || n == 24) ? 1 : 0);
      step(1);
    end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("lp_abort_busy", busy, 0);
    chk("lp_abort_done", done, 0);
    chk("lp_abort_idx", blink_index, 0);
    load(P2, 0, 0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      chk("co0_led", LED, sym(P2, n));
      chk("co0_idx", blink_index, n);
      chk("co0_busy", busy, 1);
      step(1);
    end
    chk("co0_done", done, 1);
    chk("co0_busy_end", busy, 0);
    load(P2, 9, 1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      chk("co9_idx", blink_index, n);
      chk("co9_busy", busy, 1);
      chk("co9_done", done, 0);
      step(1);
    end
    chk("co9_done_end", done, 1);
    chk("co9_busy_end", busy, 0);
    load(P1, 4, 2, 1'b0);
    for (int n = 0; n < 7; n++) begin
      chk("ab_done", done, 0);
      chk("ab_busy", busy, 1);
      step(1);
    end
    chk("ab_idx7", blink_index, 3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_busy_after", busy, 0);
    chk("ab_done_after", done, 0);
    chk("ab_led_after", LED, 0);
    chk("ab_idx_after", blink_index, 0);
    chk("ab_ready_after", load_ready, 1);
    step(1);
    chk("ab_done_late", done, 0);
    abort = 1'b1;
    load(P1, 4, 3, 1'b0);
    abort = 1'b0;
    chk("idle_abort_load_busy", busy, 1);
    chk("idle_abort_load_led", LED, sym(P1, 0));
    step(6);
    chk("ar_idx_pre", blink_index, 2);
    chk("ar_led_pre", LED, sym(P1, 2));
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_led", LED, 0);
    chk("ar_busy", busy, 0);
    chk("ar_idx", blink_index, 0);
    chk("ar_done", done, 0);
    #2;
    RST_N = 1'b1;
    step(1);
    chk("ar_ready", load_ready, 1);
    chk("ar_busy_rel", busy, 0);
    load(P1, 4, 3, 1'b0);
    chk("ar_fresh_idx", blink_index, 0);
    chk("ar_fresh_led", LED, sym(P1, 0));
    step(3);
    chk("ar_fresh_led1", LED, sym(P1, 1));
    chk("ar_fresh_idx1", blink_index, 1);
    step(9);
    chk("ar_fresh_done", done, 1);
    pattern_in = PH1;
    length     = 2;
    tick_rate  = 1;
    loop_mode  = 1'b0;
    load_valid = 1'b1;
    step(1);
    chk("hs_busy0", busy, 1);
    chk("hs_ready0", load_ready, 0);
    chk("hs_led0", LED, sym(PH1, 0));
    pattern_in = '0;
    step(1);
    chk("hs_led1", LED, sym(PH1, 1));
    chk("hs_busy1", busy, 1);
    pattern_in = PH2;
    step(1);
    chk("hs_done2", done, 1);
    chk("hs_ready2", load_ready, 1);
    chk("hs_led2", LED, 0);
    step(1);
    chk("hs_busy3", busy, 1);
    chk("hs_led3", LED, sym(PH2, 0));
    step(1);
    chk("hs_led4", LED, sym(PH2, 1));
    step(1);
    chk("hs_done5", done, 1);
    chk("hs_ready5", load_ready, 1);
    step(1);
    chk("hs_busy6", busy, 1);
    chk("hs_idx6", blink_index, 0);
    load_valid = 1'b0;
    step(2);
    chk("hs_done8", done, 1);
    step(1);
    chk("hs_idle9", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
